// File: rtl/fb_pkg.sv
// Shared frame buffer definitions: geometry, pixel/address types and the
// write arbiter state type.
package fb_pkg;

  localparam int FB_WIDTH   = 640;
  localparam int FB_HEIGHT  = 480;
  localparam int FB_WORDS   = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W  = 19;
  localparam int FB_PIXEL_W = 8;

  typedef logic [FB_ADDR_W-1:0]  fb_addr_t;
  typedef logic [FB_PIXEL_W-1:0] pixel_t;

  // IDLE and ARB both let requesters through; CLEAR locks them out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    CLEAR = 2'd2
  } fbw_state_t;

  // Linear raster address of pixel (x, y), row-major.
  function automatic fb_addr_t xy_to_addr(input logic [9:0] x, input logic [8:0] y);
    return fb_addr_t'(y) * fb_addr_t'(FB_WIDTH) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first valid
// requester at or after the pointer, pointer advances past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [SEL_W-1:0]   grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  int               sum;

  // Scan requesters starting at the pointer and grant the first valid one.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sum         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = SEL_W'(sum);
      if (enable && !grant_valid && valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Move the pointer one past the winner so it has lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame buffer write port between round-robin pixel producers and
// a full-screen clear engine; all port writes come from registers.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           clear_start,
  input  logic [DATA_W-1:0]              clear_color,
  output logic                           clear_busy,
  output logic                           clear_done,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              frame_wraddress,
  output logic [DATA_W-1:0]              frame_data,
  output logic                           frame_wren,
  output logic                           addr_err
);

  localparam int                SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(FB_WORDS);

  fbw_state_t        state;
  logic [ADDR_W-1:0] clear_ptr;
  logic [ADDR_W-1:0] clear_next;
  logic [DATA_W-1:0] fill_color;
  logic              arb_enable;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_in_range;

  // A clear request, or a fill in progress, blocks every requester.
  assign arb_enable = (state != CLEAR) && !clear_start;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .SEL_W  (SEL_W)
  ) u_rr (
    .clk        (Clk),
    .rst        (Reset),
    .enable     (arb_enable),
    .valid      (req_valid),
    .grant      (req_ready),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign sel_addr     = req_addr[grant_idx];
  assign sel_data     = req_data[grant_idx];
  assign sel_in_range = ({1'b0, sel_addr} < ADDR_LIMIT);
  assign clear_next   = clear_ptr + 1'b1;
  assign clear_busy   = (state == CLEAR);

  // clear_ptr holds the address currently on the port during a fill, so the
  // fill ends on the edge after the last address has been presented.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      clear_ptr       <= '0;
      fill_color      <= '0;
      frame_wraddress <= '0;
      frame_data      <= '0;
      frame_wren      <= 1'b0;
      clear_done      <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      frame_wren <= 1'b0;
      clear_done <= 1'b0;
      if (clear_start) begin
        state           <= CLEAR;
        clear_ptr       <= '0;
        fill_color      <= clear_color;
        frame_wraddress <= '0;
        frame_data      <= clear_color;
        frame_wren      <= 1'b1;
        clear_done      <= (LAST_ADDR == '0);
      end else if (state == CLEAR) begin
        if (clear_ptr == LAST_ADDR) begin
          state <= IDLE;
        end else begin
          clear_ptr       <= clear_next;
          frame_wraddress <= clear_next;
          frame_data      <= fill_color;
          frame_wren      <= 1'b1;
          clear_done      <= (clear_next == LAST_ADDR);
        end
      end else begin
        state <= (|req_valid) ? ARB : IDLE;
        if (grant_valid) begin
          if (sel_in_range) begin
            frame_wraddress <= sel_addr;
            frame_data      <= sel_data;
            frame_wren      <= 1'b1;
          end else begin
            addr_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
